// File: rtl/banked_data_memory.sv
// Byte-lane data memory behind a valid/ready load/store port.
// Aligned accesses of 1..LANES bytes, little-endian, with sign/zero-extended loads.
// Misaligned, oversize and out-of-range requests return a fault.
module banked_data_memory #(
  parameter int LANES     = 8,
  parameter int ADDR_BITS = 16,
  parameter int SIZE_W    = 2,
  localparam int DATA_W   = 8 * LANES
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_signed,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);

  localparam int L     = $clog2(LANES);
  localparam int ROW_W = ADDR_BITS - L;
  localparam int ROWS  = 2 ** ROW_W;

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t             state, next_state;
  logic [L-1:0]       off;
  logic [ROW_W-1:0]   row;
  logic               fault;
  logic               accept;
  logic               do_write;
  logic               do_read;
  logic [LANES-1:0]   be;
  logic [DATA_W-1:0]  wdata_sh;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  fmt;
  logic               sign;
  int                 nbytes_req;
  int                 nbytes;
  logic [SIZE_W-1:0]  size_q;
  logic               signed_q;
  logic [L-1:0]       off_q;

  assign off       = req_addr[L-1:0];
  assign row       = req_addr[ADDR_BITS-1:L];
  assign req_ready = Reset_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;
  assign do_write  = accept & req_wr & ~fault;
  assign do_read   = accept & ~req_wr & ~fault;
  assign rsp_valid = (state == RESP);
  assign wdata_sh  = req_wdata << {off, 3'b000};

  // Request decode: fault detection and store byte enables
  always_comb begin
    fault      = 1'b0;
    nbytes_req = 1 << req_size;
    if (req_size > SIZE_W'(L)) fault = 1'b1;
    for (int i = 0; i < L; i++) begin
      if ((i < int'(req_size)) && off[i]) fault = 1'b1;
    end
    if (req_addr[63:ADDR_BITS] != '0) fault = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      be[i] = (i >= int'(off)) && (i < int'(off) + nbytes_req);
    end
  end

  // One RAM per byte lane: byte-enabled write and registered read
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] mem [ROWS];
    logic [7:0] rd_lane;

    // Lane write on the accepting edge, lane read captured for the RD cycle
    always_ff @(posedge Clk) begin
      if (do_write && be[i]) mem[row] <= wdata_sh[8*i +: 8];
      if (do_read) rd_lane <= mem[row];
    end

    assign rd_data[8*i +: 8] = rd_lane;
  end

  // Load formatting: right-justify the selected bytes and extend
  always_comb begin
    shifted = rd_data >> {off_q, 3'b000};
    nbytes  = 1 << size_q;
    fmt     = '0;
    sign    = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      if (b < nbytes) begin
        fmt[8*b +: 8] = shifted[8*b +: 8];
        sign          = shifted[8*b + 7];
      end
    end
    if (signed_q && (nbytes < LANES)) begin
      for (int b = 0; b < LANES; b++) begin
        if (b >= nbytes) fmt[8*b +: 8] = {8{sign}};
      end
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; a response slot frees up in the same cycle it is consumed
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = do_read ? RD : RESP;
      RD:   next_state = RESP;
      RESP: if (rsp_ready) next_state = accept ? (do_read ? RD : RESP) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Response registers and captured load attributes; rdata is zero unless a response is shown
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      off_q     <= '0;
    end else if (accept) begin
      rsp_rdata <= '0;
      rsp_fault <= fault;
      size_q    <= req_size;
      signed_q  <= req_signed;
      off_q     <= off;
    end else if (state == RD) begin
      rsp_rdata <= fmt;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_banked_data_memory.sv
// Directed scoreboard bench for banked_data_memory (LANES=8, ADDR_BITS=16, SIZE_W=3).
module tb_banked_data_memory;

  localparam int LANES     = 8;
  localparam int ADDR_BITS = 16;
  localparam int SIZE_W    = 3;
  localparam int DATA_W    = 64;

  logic              Clk;
  logic              Reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [SIZE_W-1:0] req_size;
  logic              req_signed;
  logic [63:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;

  typedef struct {
    logic        fault;
    logic [63:0] data;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  banked_data_memory #(
    .LANES(LANES), .ADDR_BITS(ADDR_BITS), .SIZE_W(SIZE_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  // Free-running clock, 10 time units per cycle
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each consumed response against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (Reset_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp_queue_depth", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_fault"}, 64'(rsp_fault), 64'(e.fault));
          check({e.tag, "_rdata"}, rsp_rdata, e.data);
        end
      end
    end
  end

  // Drive one request (called near a falling edge), record the expectation at acceptance,
  // optionally wait for the response and check its latency in cycles
  task automatic applyStimulus(input logic wr, input logic [SIZE_W-1:0] size, input logic sgn,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic efault, input logic [63:0] edata,
                               input string tag, input int elat, input bit wait_rsp);
    int   n;
    exp_t e;
    req_wr     = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check({tag, "_accept"}, 64'(req_ready), 64'd1);
    @(posedge Clk);
    if (n < 20) begin
      e.fault = efault;
      e.data  = edata;
      e.tag   = tag;
      sb.push_back(e);
    end
    @(negedge Clk);
    req_valid = 1'b0;
    if (wait_rsp) begin
      n = 1;
      #1;
      while (!rsp_valid && n < 20) begin
        @(negedge Clk);
        #1;
        n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(elat));
    end
  endtask

  // Hold a pending response with rsp_ready low and confirm it stays put
  task automatic checkOutput(input logic [63:0] edata, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", rsp_rdata, edata);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      @(negedge Clk);
      #1;
    end
  endtask

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout errors=%0d", errors);
    $fatal(1, "[TB] time limit reached");
  end

  // Directed sequence
  initial begin
    exp_t dropped;
    Reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_size   = '0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_fault", 64'(rsp_fault), 64'd0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    $display("[TB] dword store and unsigned loads");
    applyStimulus(1, 3'd3, 0, 64'h10, 64'h1122334455667788, 0, 64'h0, "st_dw10", 1, 1);
    applyStimulus(0, 3'd0, 0, 64'h13, 64'h0, 0, 64'h55, "ld_b13", 2, 1);
    applyStimulus(0, 3'd1, 0, 64'h14, 64'h0, 0, 64'h3344, "ld_h14", 2, 1);
    applyStimulus(0, 3'd3, 0, 64'h10, 64'h0, 0, 64'h1122334455667788, "ld_dw10", 2, 1);
    applyStimulus(0, 3'd2, 1, 64'h14, 64'h0, 0, 64'h11223344, "ld_sw14", 2, 1);

    $display("[TB] byte store and extension");
    applyStimulus(1, 3'd0, 0, 64'h12, 64'hDEADBEEFCAFEBAF0, 0, 64'h0, "st_b12", 1, 1);
    applyStimulus(0, 3'd0, 1, 64'h12, 64'h0, 0, 64'hFFFFFFFFFFFFFFF0, "ld_sb12", 2, 1);
    applyStimulus(0, 3'd0, 0, 64'h12, 64'h0, 0, 64'hF0, "ld_ub12", 2, 1);
    applyStimulus(0, 3'd3, 1, 64'h10, 64'h0, 0, 64'h1122334455F07788, "ld_dw10b", 2, 1);
    applyStimulus(1, 3'd1, 0, 64'h18, 64'h8001, 0, 64'h0, "st_h18", 1, 1);
    applyStimulus(0, 3'd1, 1, 64'h18, 64'h0, 0, 64'hFFFFFFFFFFFF8001, "ld_sh18", 2, 1);

    $display("[TB] faults");
    applyStimulus(1, 3'd2, 0, 64'h16, 64'hFFFFFFFF, 1, 64'h0, "st_w16_mis", 1, 1);
    applyStimulus(0, 3'd3, 0, 64'h10, 64'h0, 0, 64'h1122334455F07788, "ld_dw10c", 2, 1);
    applyStimulus(0, 3'd0, 0, 64'h10000, 64'h0, 1, 64'h0, "ld_oor", 1, 1);
    applyStimulus(0, 3'd4, 0, 64'h10, 64'h0, 1, 64'h0, "ld_size4", 1, 1);
    applyStimulus(0, 3'd1, 1, 64'h11, 64'h0, 1, 64'h0, "ld_h11_mis", 1, 1);

    $display("[TB] response backpressure then back-to-back");
    @(negedge Clk);
    rsp_ready = 1'b0;
    applyStimulus(0, 3'd3, 0, 64'h10, 64'h0, 0, 64'h1122334455F07788, "ld_hold", 2, 1);
    checkOutput(64'h1122334455F07788, 3);
    rsp_ready = 1'b1;
    #1;
    check("release_req_ready", 64'(req_ready), 64'd1);
    applyStimulus(1, 3'd3, 0, 64'h20, 64'hA5A5A5A5A5A5A5A5, 0, 64'h0, "st_dw20", 1, 0);
    applyStimulus(0, 3'd3, 0, 64'h20, 64'h0, 0, 64'hA5A5A5A5A5A5A5A5, "ld_dw20_b2b", 2, 1);

    $display("[TB] reset during load");
    applyStimulus(1, 3'd3, 0, 64'h30, 64'h0123456789ABCDEF, 0, 64'h0, "st_dw30", 1, 1);
    applyStimulus(0, 3'd3, 0, 64'h30, 64'h0, 0, 64'h0123456789ABCDEF, "ld_dropped", 2, 0);
    Reset_n = 1'b0;
    dropped = sb.pop_back();
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      #1;
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    applyStimulus(0, 3'd3, 0, 64'h30, 64'h0, 0, 64'h0123456789ABCDEF, "ld_dw30", 2, 1);

    repeat (3) @(negedge Clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
